// File: rtl/gen_pulso_repeticion_if.sv
// -----------------------------------------------------------------------------
// gen_pulso_repeticion_if
// Bundle between a button conditioning stage and the auto-repeat pulse
// generator.
//
// Signals:
//   incremento  debounced button level, 1 = pressed (driven by the master)
//   pulso       single-cycle increment strobe       (driven by the slave)
//   mantenido   1 while the button is auto-repeating (driven by the slave)
//   n_pulsos    pulses issued in current/last press, saturating at 255
//
// Modports:
//   master  the side that owns the button level (debouncer / testbench)
//   slave   the pulse generator
// -----------------------------------------------------------------------------
interface gen_pulso_repeticion_if;

   logic       incremento;
   logic       pulso;
   logic       mantenido;
   logic [7:0] n_pulsos;

   modport master (
      output incremento,
      input  pulso,
      input  mantenido,
      input  n_pulsos
   );

   modport slave (
      input  incremento,
      output pulso,
      output mantenido,
      output n_pulsos
   );

endinterface : gen_pulso_repeticion_if

// File: rtl/gen_pulso_repeticion.sv
// -----------------------------------------------------------------------------
// gen_pulso_repeticion
// Turns a debounced button level into single-cycle increment pulses for the
// RTC setting logic. A new press gives one pulse immediately; holding the
// button auto-repeats after RETARDO_INICIAL cycles and then every
// PERIODO_REPETICION cycles. One instance per button.
//
// Parameters:
//   RETARDO_INICIAL     cycles from the first pulse to the first repeat (>= 2)
//   PERIODO_REPETICION  cycles between consecutive repeat pulses (>= 2)
//   CNT_W               width of the cycle counter, must hold
//                       max(RETARDO_INICIAL, PERIODO_REPETICION) - 1
//
// Ports:
//   clk    system clock, everything on the rising edge
//   reset  synchronous reset, active-low
//   bus    slave side of gen_pulso_repeticion_if
//            incremento (in)  button level
//            pulso      (out) single-cycle strobe, registered
//            mantenido  (out) 1 while in the auto-repeat phase, registered
//            n_pulsos   (out) pulses of the current/last press, registered
// -----------------------------------------------------------------------------
module gen_pulso_repeticion #(
   parameter int RETARDO_INICIAL    = 8,
   parameter int PERIODO_REPETICION = 4,
   parameter int CNT_W              = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   gen_pulso_repeticion_if.slave  bus
);

   // Terminal counts; the counter starts at zero on the pulse edge, so a
   // terminal value of N-1 spaces pulses exactly N cycles apart.
   localparam logic [CNT_W-1:0] TC_RETARDO = CNT_W'(RETARDO_INICIAL - 1);
   localparam logic [CNT_W-1:0] TC_PERIODO = CNT_W'(PERIODO_REPETICION - 1);
   localparam logic [CNT_W-1:0] CNT_CERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_UNO    = CNT_W'(1);
   localparam logic [7:0]       N_MAX      = 8'd255;
   localparam logic [7:0]       N_UNO      = 8'd1;
   localparam logic [7:0]       N_CERO     = 8'd0;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      RETARDO = 2'd1,
      REPITE  = 2'd2
   } estado_t;

   // Pulse count that sticks at its maximum instead of wrapping, so a very
   // long hold never reports a small count.
   function automatic logic [7:0] incr_saturado(input logic [7:0] valor);
      logic [7:0] resultado;
      if (valor == N_MAX) begin
         resultado = N_MAX;
      end else begin
         resultado = valor + N_UNO;
      end
      return resultado;
   endfunction

   estado_t          estado_r;
   logic [CNT_W-1:0] cnt_r;
   logic             prev_r;
   logic             pulso_r;
   logic             mantenido_r;
   logic [7:0]       n_pulsos_r;

   assign bus.pulso     = pulso_r;
   assign bus.mantenido = mantenido_r;
   assign bus.n_pulsos  = n_pulsos_r;

   // Press/hold FSM with cycle counter, rise-detect flop and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_r    <= ESPERA;
         cnt_r       <= CNT_CERO;
         // Treat the button as already pressed so a hold across reset
         // needs a release before it can pulse again.
         prev_r      <= 1'b1;
         pulso_r     <= 1'b0;
         mantenido_r <= 1'b0;
         n_pulsos_r  <= N_CERO;
      end else begin
         prev_r  <= bus.incremento;
         // Strobe is one cycle wide; only a pulsing branch raises it.
         pulso_r <= 1'b0;
         case (estado_r)
            ESPERA: begin
               mantenido_r <= 1'b0;
               cnt_r       <= CNT_CERO;
               if (bus.incremento && !prev_r) begin
                  // New press: immediate pulse, old count discarded.
                  pulso_r    <= 1'b1;
                  n_pulsos_r <= N_UNO;
                  estado_r   <= RETARDO;
               end else begin
                  estado_r   <= ESPERA;
               end
            end

            RETARDO: begin
               if (!bus.incremento) begin
                  // Release wins over a coincident terminal count.
                  estado_r    <= ESPERA;
                  cnt_r       <= CNT_CERO;
                  mantenido_r <= 1'b0;
               end else if (cnt_r == TC_RETARDO) begin
                  pulso_r     <= 1'b1;
                  cnt_r       <= CNT_CERO;
                  n_pulsos_r  <= incr_saturado(n_pulsos_r);
                  mantenido_r <= 1'b1;
                  estado_r    <= REPITE;
               end else begin
                  cnt_r       <= cnt_r + CNT_UNO;
                  estado_r    <= RETARDO;
               end
            end

            REPITE: begin
               if (!bus.incremento) begin
                  estado_r    <= ESPERA;
                  cnt_r       <= CNT_CERO;
                  mantenido_r <= 1'b0;
               end else if (cnt_r == TC_PERIODO) begin
                  // Pulses keep coming after the count has saturated.
                  pulso_r     <= 1'b1;
                  cnt_r       <= CNT_CERO;
                  n_pulsos_r  <= incr_saturado(n_pulsos_r);
                  mantenido_r <= 1'b1;
                  estado_r    <= REPITE;
               end else begin
                  cnt_r       <= cnt_r + CNT_UNO;
                  mantenido_r <= 1'b1;
                  estado_r    <= REPITE;
               end
            end

            default: begin
               // Unreachable encoding: fall back to idle without pulsing.
               estado_r    <= ESPERA;
               cnt_r       <= CNT_CERO;
               mantenido_r <= 1'b0;
            end
         endcase
      end
   end

endmodule : gen_pulso_repeticion
